// File: rtl/drop32_uart_rx.sv
// ============================================================================
// drop32_uart_rx
// ----------------------------------------------------------------------------
// 8N1 UART receiver for the drop32 SoC.
//
// A 2-flop synchroniser brings the asynchronous serial line into the i_clk
// domain. A five-state FSM (IDLE/START/DATA/STOP/BREAK) times each bit from a
// tick counter that restarts at every start-bit detection. The counter checks
// the start bit at its midpoint and samples every following bit one full bit
// period later. The receiver assembles bytes LSB first. Completed bytes go
// into a small first-word-fall-through FIFO, which the SoC bus bridge drains
// through a valid/ready handshake.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active low (0 = reset)
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data       FIFO head byte (0 when the FIFO is empty)
//   o_valid      FIFO non-empty
//   i_ready      consumer takes o_data this cycle (pop when o_valid=1)
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a byte was dropped because the FIFO was full
//   i_clr_err    single-cycle pulse clearing both sticky flags
//   o_level      current FIFO occupancy
// ============================================================================
module drop32_uart_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_clr_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int AW = $clog2(FIFO_DEPTH);     // FIFO address width
    localparam int PW = AW + 1;                 // pointer width (extra wrap bit)
    localparam int TW = $clog2(CLKS_PER_BIT);   // tick counter width

    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------------
    // Both flops reset to the idle level so that releasing reset never looks
    // like a falling start edge.
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    state_t          state_q,   state_d;
    logic [TW-1:0]   tick_q,    tick_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q,   shift_d;
    logic            push_req;      // stop bit good: byte complete this cycle
    logic            frame_set;     // stop bit low: raise the framing flag
    logic            tick_last;

    assign tick_last = (tick_q == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = S_START;
                    tick_d    = '0;
                    bit_idx_d = '0;
                end
            end

            // Check the start bit at its midpoint. A line that is back high by
            // then was a glitch, so the FSM drops it without raising a flag.
            S_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d  = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            // Sampling from mid-start means each full bit period lands near
            // the centre of the next data bit.
            S_DATA: begin
                if (tick_last) begin
                    tick_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d         = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            S_STOP: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            // A line held low after a bad stop bit is a break. Wait for the
            // line to return high so that the break produces one error only,
            // not a stream of all-zero frames.
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------------
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  level;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           overrun_set;

    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_P);
    assign pop   = !empty && i_ready;

    // A pop in the same cycle frees the slot that a full FIFO would otherwise
    // lack, so the FIFO accepts the byte and the overrun flag stays clear.
    assign push_ok     = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // The FIFO storage has no reset. o_data is masked while the FIFO is empty,
    // so stale entries never reach the output.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= shift_q;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    // A set event has priority over a clear pulse in the same cycle, so the
    // consumer cannot miss an error.
    logic frame_err_q, frame_err_d;
    logic overrun_q,   overrun_d;

    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (frame_set) begin
            frame_err_d = 1'b1;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_valid     = !empty;
    assign o_data      = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign o_level     = level;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule
